// File: rtl/card_board.sv
// card_board: owns the 10-slot card board read by the cursor/adder selector.
// Deals pseudo-random cards (1..9) from an 8-bit LFSR, accepts two-slot picks,
// writes the mod-10 sum back into the board, keeps a saturating score of pairs
// that summed to ten, and flags game end.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, num          deal a new board with num (clamped 1..5) columns per row
//   pick_valid/slot     slot pick from the selector; pick_ready shows acceptance
//   status[39:0]        board, slot s at status[4s+:4], 0 = empty
//   sel_index           first pick held, 4'hF when none
//   sum_value/sum_valid last combine result and its one-cycle strobe
//   score               saturating count of ten-sums
//   busy                dealing in progress
//   game_over           fewer than two nonempty slots on a dealt board
module card_board #(
  parameter logic [7:0] SEED    = 8'hA5,
  parameter int         SCORE_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         num,
  input  logic               pick_valid,
  input  logic [3:0]         pick_slot,
  output logic               pick_ready,
  output logic [39:0]        status,
  output logic [3:0]         sel_index,
  output logic [3:0]         sum_value,
  output logic               sum_valid,
  output logic [SCORE_W-1:0] score,
  output logic               busy,
  output logic               game_over
);

  typedef enum logic [1:0] {NOBOARD, DEAL, IDLE, HELD} state_t;

  state_t          state;
  logic [7:0]      lfsr;
  logic [2:0]      n_r;
  logic [3:0]      deal_idx;
  logic [9:0][3:0] board;

  assign status = board;

  // Column count clamp applied when start is accepted
  logic [2:0] n_clamp;
  always_comb begin
    if (num == 3'd0)     n_clamp = 3'd1;
    else if (num > 3'd5) n_clamp = 3'd5;
    else                 n_clamp = num;
  end

  // Card from the low LFSR nibble, folded into 1..9
  logic [3:0] card;
  always_comb begin
    if (lfsr[3:0] == 4'd0)     card = 4'd1;
    else if (lfsr[3:0] > 4'd9) card = lfsr[3:0] - 4'd6;
    else                       card = lfsr[3:0];
  end

  // Deal order: row 0 columns first, then row 1 (slot 5 onward)
  logic [3:0] deal_slot;
  logic       deal_last;
  always_comb begin
    if (deal_idx < {1'b0, n_r}) deal_slot = deal_idx;
    else                        deal_slot = deal_idx - {1'b0, n_r} + 4'd5;
    deal_last = (deal_idx == ({n_r, 1'b0} - 4'd1));
  end

  // Board widened to 16 entries so out-of-range pick slots read as empty
  logic [15:0][3:0] board16;
  always_comb begin
    board16       = '0;
    board16[9:0]  = board;
  end

  logic [3:0] pick_card, held_card;
  logic       pick_active, pick_ok;
  assign pick_card   = board16[pick_slot];
  assign held_card   = board16[sel_index];
  assign pick_active = (pick_slot < {1'b0, n_r}) ||
                       ((pick_slot >= 4'd5) && (pick_slot < 4'd5 + {1'b0, n_r}));
  assign pick_ok     = pick_valid && pick_active && (pick_card != 4'd0);

  // Mod-10 combine of held card and picked card
  logic [4:0] sum5;
  logic [3:0] r_card;
  always_comb begin
    sum5 = {1'b0, held_card} + {1'b0, pick_card};
    if (sum5 >= 5'd10) r_card = 4'(sum5 - 5'd10);
    else               r_card = sum5[3:0];
  end

  // Game end looks at the board as it stands now, so it lags the update by one
  logic [3:0] filled;
  logic       go_next;
  always_comb begin
    filled = '0;
    for (int i = 0; i < 10; i++) filled = filled + {3'b0, |board[i]};
    go_next = ((state == IDLE) || (state == HELD)) && !start && (filled < 4'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= NOBOARD;
      lfsr       <= SEED;
      n_r        <= 3'd1;
      deal_idx   <= '0;
      board      <= '0;
      sel_index  <= 4'hF;
      sum_value  <= '0;
      sum_valid  <= 1'b0;
      score      <= '0;
      busy       <= 1'b0;
      pick_ready <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      // x^8+x^6+x^5+x^4+1, free-running
      lfsr      <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      sum_valid <= 1'b0;
      game_over <= go_next;
      if (start) begin
        // Restart wins over everything, including a deal in flight
        state      <= DEAL;
        n_r        <= n_clamp;
        deal_idx   <= '0;
        board      <= '0;
        score      <= '0;
        sel_index  <= 4'hF;
        busy       <= 1'b1;
        pick_ready <= 1'b0;
      end else begin
        case (state)
          DEAL: begin
            board[deal_slot] <= card;
            deal_idx         <= deal_idx + 4'd1;
            if (deal_last) begin
              state      <= IDLE;
              busy       <= 1'b0;
              pick_ready <= 1'b1;
            end
          end
          IDLE: if (pick_ok) begin
            sel_index <= pick_slot;
            state     <= HELD;
          end
          HELD: begin
            if (pick_valid && (pick_slot == sel_index)) begin
              sel_index <= 4'hF;
              state     <= IDLE;
            end else if (pick_ok) begin
              board[sel_index] <= 4'd0;
              board[pick_slot] <= r_card;
              sum_value        <= r_card;
              sum_valid        <= 1'b1;
              if ((r_card == 4'd0) && (score != {SCORE_W{1'b1}}))
                score <= score + 1'b1;
              sel_index <= 4'hF;
              state     <= IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_card_board.sv
module tb_card_board;

  localparam logic [7:0] SEED    = 8'hA5;
  localparam int         SCORE_W = 2;
  localparam int         SMAX    = (1 << SCORE_W) - 1;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [2:0]         num;
  logic               pick_valid;
  logic [3:0]         pick_slot;
  logic               pick_ready;
  logic [39:0]        status;
  logic [3:0]         sel_index;
  logic [3:0]         sum_value;
  logic               sum_valid;
  logic [SCORE_W-1:0] score;
  logic               busy;
  logic               game_over;

  card_board #(.SEED(SEED), .SCORE_W(SCORE_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num(num),
    .pick_valid(pick_valid), .pick_slot(pick_slot), .pick_ready(pick_ready),
    .status(status), .sel_index(sel_index), .sum_value(sum_value),
    .sum_valid(sum_valid), .score(score), .busy(busy), .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: board contents, game phase, held slot, score
  int         mb[10];
  int         mphase;   // 0 no board, 1 dealing, 2 playing
  int         mheld;    // -1 when nothing held
  int         mn;
  int         mscore;
  int         msum;
  bit         mpulse;
  bit         mgo;
  logic [7:0] ml;       // LFSR value currently inside the DUT
  int         dq_slot[$];
  int         dq_card[$];
  bit         sat_hit;

  function automatic logic [7:0] nxt(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic int card_of(input logic [7:0] l);
    int v;
    v = int'(l[3:0]);
    if (v == 0) return 1;
    if (v > 9) return v - 6;
    return v;
  endfunction

  function automatic int clampn(input int x);
    if (x == 0) return 1;
    if (x > 5) return 5;
    return x;
  endfunction

  function automatic bit active(input int s);
    return (s < mn) || (s >= 5 && s < 5 + mn);
  endfunction

  function automatic int ncount();
    int c;
    c = 0;
    for (int i = 0; i < 10; i++) if (mb[i] != 0) c++;
    return c;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [39:0] es;
    for (int i = 0; i < 10; i++) es[4*i +: 4] = 4'(mb[i]);
    chk("status", status, es);
    chk("sel_index", sel_index, (mheld < 0) ? 4'hF : 4'(mheld));
    chk("sum_valid", sum_valid, mpulse);
    chk("sum_value", sum_value, msum);
    chk("score", score, mscore);
    chk("busy", busy, mphase == 1);
    chk("pick_ready", pick_ready, mphase == 2);
    chk("game_over", game_over, mgo);
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge
  task automatic cyc(input bit st, input int nm, input bit pv, input int ps);
    bit go;
    bit ok;
    int s;
    int r;
    logic [7:0] l;
    start      = st;
    num        = nm[2:0];
    pick_valid = pv;
    pick_slot  = ps[3:0];
    go     = (mphase == 2) && !st && (ncount() < 2);
    mpulse = 1'b0;
    if (st) begin
      mphase = 1; mn = clampn(nm); mscore = 0; mheld = -1;
      for (int i = 0; i < 10; i++) mb[i] = 0;
      dq_slot.delete(); dq_card.delete();
      l = ml;
      for (int k = 0; k < 2 * mn; k++) begin
        l = nxt(l);
        dq_slot.push_back((k < mn) ? k : k - mn + 5);
        dq_card.push_back(card_of(l));
      end
    end else if (mphase == 1) begin
      if (dq_slot.size() > 0) mb[dq_slot.pop_front()] = dq_card.pop_front();
      if (dq_slot.size() == 0) mphase = 2;
    end else if (mphase == 2 && pv) begin
      ok = (ps <= 9) && active(ps) && (mb[ps] != 0);
      if (mheld < 0) begin
        if (ok) mheld = ps;
      end else if (ps == mheld) begin
        mheld = -1;
      end else if (ok) begin
        s = mb[mheld] + mb[ps];
        r = s % 10;
        mb[mheld] = 0;
        mb[ps] = r;
        msum = r;
        mpulse = 1'b1;
        if (r == 0 && mscore < SMAX) mscore++;
        mheld = -1;
      end
    end
    mgo = go;
    @(posedge clk);
    #1;
    ml = nxt(ml);
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; pick_valid = 1'b0; pick_slot = 4'd0; num = 3'd0;
    #2;
    for (int i = 0; i < 10; i++) mb[i] = 0;
    mphase = 0; mheld = -1; mscore = 0; msum = 0; mpulse = 0; mgo = 0; mn = 1;
    dq_slot.delete(); dq_card.delete();
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ml = SEED;
    check_all();
  endtask

  task automatic do_deal(input int nm);
    int bc;
    bc = 0;
    cyc(1'b1, nm, 1'b0, 0);
    while (busy === 1'b1 && bc < 40) begin
      bc++;
      cyc(1'b0, 0, 1'b0, 0);
    end
    chk("busy_len", bc, 2 * clampn(nm));
    for (int s = 0; s < 10; s++)
      if (active(s)) chk("card_range", (status[4*s +: 4] >= 4'd1) && (status[4*s +: 4] <= 4'd9), 1);
  endtask

  // Greedy player: prefer ten-pairs, then merges that set up a ten-pair
  task automatic play_board();
    int a;
    int b;
    int r;
    for (int it = 0; it < 12 && ncount() >= 2; it++) begin
      a = -1; b = -1;
      for (int i = 0; i < 10; i++)
        for (int j = i + 1; j < 10; j++)
          if (a < 0 && mb[i] != 0 && mb[j] != 0 && mb[i] + mb[j] == 10) begin a = i; b = j; end
      for (int i = 0; i < 10; i++)
        for (int j = i + 1; j < 10; j++)
          if (a < 0 && mb[i] != 0 && mb[j] != 0) begin
            r = (mb[i] + mb[j]) % 10;
            for (int k = 0; k < 10; k++)
              if (a < 0 && k != i && k != j && mb[k] != 0 && mb[k] + r == 10) begin a = i; b = j; end
          end
      for (int i = 0; i < 10; i++)
        if (mb[i] != 0) begin
          if (a < 0) a = i;
          else if (b < 0 && i != a) b = i;
        end
      if (mb[a] + mb[b] == 10 && mscore == SMAX) sat_hit = 1'b1;
      cyc(1'b0, 0, 1'b1, a);
      cyc(1'b0, 0, 1'b1, b);
      if (sat_hit) chk("score_sat", score, SMAX);
    end
    cyc(1'b0, 0, 1'b0, 0);
    cyc(1'b0, 0, 1'b0, 0);
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; num = 3'd0; pick_valid = 1'b0; pick_slot = 4'd0;
    sat_hit = 1'b0;
    #1;
    do_reset();

    // Reset in the middle of a deal, then a pick that must be ignored
    cyc(1'b1, 3, 1'b0, 0);
    cyc(1'b0, 0, 1'b0, 0);
    cyc(1'b0, 0, 1'b0, 0);
    do_reset();
    cyc(1'b0, 0, 1'b1, 0);
    cyc(1'b0, 0, 1'b0, 0);

    // n=3 deal, then edge picks
    do_deal(3);
    cyc(1'b0, 0, 1'b1, 2);   // hold 2
    cyc(1'b0, 0, 1'b1, 2);   // deselect, no pulse
    cyc(1'b0, 0, 1'b1, 4);   // inactive, idle
    cyc(1'b0, 0, 1'b1, 12);  // out of range, idle
    cyc(1'b0, 0, 1'b1, 0);   // hold 0
    cyc(1'b0, 0, 1'b1, 4);   // inactive, held
    cyc(1'b0, 0, 1'b1, 12);  // out of range, held
    cyc(1'b0, 0, 1'b1, 9);   // inactive, held
    cyc(1'b0, 0, 1'b1, 5);   // combine 0 with 5
    cyc(1'b0, 0, 1'b0, 0);
    cyc(1'b0, 0, 1'b1, 0);   // empty, idle
    cyc(1'b0, 0, 1'b1, 1);   // hold 1
    cyc(1'b0, 0, 1'b1, 0);   // empty, held
    cyc(1'b0, 0, 1'b1, 1);   // deselect

    // start coincident with a valid second pick, then a restart mid-deal
    cyc(1'b0, 0, 1'b1, 6);
    cyc(1'b1, 3, 1'b1, 7);
    cyc(1'b0, 0, 1'b0, 0);
    cyc(1'b0, 0, 1'b0, 0);
    do_deal(2);

    // Column clamps
    do_deal(0);
    do_deal(7);

    // Random back-to-back picks on a full board
    for (int i = 0; i < 60; i++)
      cyc(1'b0, 0, ($urandom % 4) != 0, int'($urandom_range(0, 15)));

    // Game over with one column
    do_deal(0);
    cyc(1'b0, 0, 1'b1, 0);
    cyc(1'b0, 0, 1'b1, 5);
    cyc(1'b0, 0, 1'b0, 0);
    chk("game_over_set", game_over, 1);
    cyc(1'b1, 4, 1'b0, 0);
    chk("game_over_clr", game_over, 0);
    cyc(1'b0, 0, 1'b0, 0);

    // Play boards until a ten-pair lands on an already saturated score
    for (int d = 0; d < 100 && !sat_hit; d++) begin
      do_deal(5);
      play_board();
    end
    chk("sat_reached", sat_hit, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/card_board.md
# card_board

Owns the 10-slot card board that the cursor/adder selector reads. Deals random cards, accepts slot picks from the selector, and writes the combined result back into the board. Also keeps the score and detects game end. It sits upstream of the selector's `status` input and downstream of its selection output, closing the read/modify/write loop on the board.

## Interface
Parameters:
- `SEED`, 8'hA5: LFSR reset value; must be nonzero.
- `SCORE_W`, 8: score counter width.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that deals a new board and clears the score; accepted in any state.
- `num`  in  3  active columns per row; sampled only when `start` is accepted.
- `pick_valid`  in  1  pick request from the selector.
- `pick_slot`  in  4  picked slot, 0..9; slot s occupies `status[4s+:4]`.
- `pick_ready`  out  1  high when picks are accepted.
- `status`  out  40  board contents; 4'd0 means empty, 1..9 are card values.
- `sel_index`  out  4  slot held as first pick; 4'hF when no slot is held.
- `sum_value`  out  4  last combine result, 0..9.
- `sum_valid`  out  1  one-cycle pulse when `sum_value` updates.
- `score`  out  SCORE_W  count of pairs that summed to 10; saturates at all-ones.
- `busy`  out  1  high while dealing.
- `game_over`  out  1  board dealt and fewer than 2 nonempty active slots remain.

## Operation
- **Active columns.**
  - `n = num` is clamped to 1..5: 0 becomes 1, and 6 or 7 become 5.
  - Active slots are 0..n-1 (row 0) and 5..5+n-1 (row 1).
  - Inactive slots always hold 0.
- **LFSR.**
  - 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1.
  - Shifts every cycle after reset, in every state.
  - Card derivation: `v = lfsr[3:0]`; card = 1 if v==0, v-6 if v>9, else v. The result is always 1..9.
- **States.**
  - NOBOARD: reset state. `pick_ready`=0, `game_over`=0.
  - DEAL: writes one active slot per cycle, in order 0..n-1 then 5..5+n-1, and zeroes inactive slots as part of entry. Lasts 2n cycles, then goes to IDLE.
  - IDLE: `pick_ready`=1, nothing held.
  - HELD: `pick_ready`=1, first pick A held in `sel_index`.
- **Pick in IDLE.**
  - Slot inactive, slot empty, or `pick_slot`>9: ignored, no state change.
  - Otherwise: A = slot, go to HELD.
- **Pick in HELD.**
  - Same slot as A: deselect, `sel_index`=F, go to IDLE, no pulse.
  - Invalid or empty slot: ignored, stay in HELD.
  - Otherwise, for slot B:
    - Compute `s = a+b` in 5 bits, and `r = s>=10 ? s-10 : s`.
    - Write slot A=0.
    - Write slot B=r. If r==0, slot B becomes empty.
    - Pulse `sum_valid` with `sum_value`=r.
    - If r==0, increment `score` (saturating).
    - Go to IDLE.
- **`start` priority.** `start` beats any pick in the same cycle. On accept:
  - score=0, `sel_index`=F.
  - Enter DEAL and restart the deal from slot 0, including when `start` arrives mid-deal.
- **`game_over`.**
  - Registered.
  - Evaluated from the post-update board in IDLE/HELD.
  - Forced 0 in NOBOARD and DEAL.

## Timing
- **Reset values:**
  - `status`=0, `sel_index`=4'hF, `sum_value`=0, `sum_valid`=0, `score`=0.
  - `busy`=0, `pick_ready`=0, `game_over`=0.
  - lfsr=SEED, state NOBOARD.
- **Deal:**
  - `start` accepted at edge T: `busy`=1 from T+1 through T+2n.
  - The slot dealt at edge T+k uses the LFSR value present before that edge.
  - `busy`=0 and `pick_ready`=1 at T+2n+1.
- **Picks:**
  - A pick is accepted when `pick_valid & pick_ready` at edge T.
  - `sel_index`, `status`, `sum_value`, `sum_valid`, and `score` all update at T+1.
  - `sum_valid` is high exactly one cycle.
  - `game_over` reflects the T+1 board at T+2.
- **Throughput:** one pick per cycle with no bubbles.
- **Reset mid-operation:** asserting `rst_n`=0 in any state immediately restores all reset values; no partial deal persists.

## Test plan
- **Reset:** assert `rst_n`=0 mid-DEAL, then release → `status`=0, `score`=0, `sel_index`=F, `pick_ready`=0. A pick on slot 0 is ignored.
- **Deal:** `start` with `num`=3 → `busy` high for 6 cycles. Slots 0,1,2,5,6,7 match the bench LFSR model (SEED=A5), all in 1..9. Slots 3,4,8,9 read 0. `num`=0 deals only slots 0 and 5; `num`=7 deals all 10 slots.
- **Combine:** board with slot 0=7, slot 5=8 (seeded via model); pick 0 then 5 → at the second pick +1: `sel_index`=F, slot 0=0, slot 5=5, `sum_value`=5, one-cycle `sum_valid`, `score` unchanged.
- **Sum to ten:** slot 1=3, slot 6=7 → both slots become 0, `sum_value`=0, `score`+1. Preload `score` via 255 such pairs to check it saturates at 255.
- **Edge picks:** pick slot 2 twice → deselect, no pulse. Pick an empty slot, slot 4 with n=3, or slot 12 → ignored in both IDLE and HELD. `start` coincident with a valid second pick → the pick is dropped and the deal restarts.
- **Game over:** with n=1, combine slots 0 and 5 → `game_over`=1 two cycles after the accept edge. `start` then clears it during DEAL.
